fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the 8-bit core, sitting directly upstream of the instruction decoder.
- Holds the program counter, requests 16-bit instruction words from program memory over a req/ack handshake, and latches each word into the instruction register that drives the decoder.
- Consumes the decoder's jump controls (cnt_wr_en, add_offset, literal_adr) to compute the next PC.
- Produces a one-cycle instr_valid strobe; all downstream state writes (register file, status register) are gated by it.

Parameters:
PC_WIDTH, 8, program counter and program memory address width
INSTR_WIDTH, 16, instruction word width
RESET_VECTOR, 0, PC value loaded on reset
WDT_LIMIT, 15, max wait cycles per fetch before fault (used only with the optional feature)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
mem_req  output  1  fetch request to program memory
mem_addr  output  PC_WIDTH  fetch address, equals pc while mem_req=1
mem_ack  input  1  memory returns valid mem_rdata this cycle
mem_rdata  input  INSTR_WIDTH  instruction word from memory
instruction  output  INSTR_WIDTH  instruction register, to decoder
instr_valid  output  1  instruction is in its execute cycle
pc  output  PC_WIDTH  address of the instruction currently held or being fetched
cnt_wr_en  input  1  from decoder: load the PC (absolute or relative)
add_offset  input  1  from decoder: the PC load is relative
literal_adr  input  PC_WIDTH  from decoder: jump target or offset
halt  input  1  stop after the current instruction
fetch_err  output  1  sticky fetch timeout fault (tied 0 when the feature is off)

Behaviour:
- Reset values:
  - pc=RESET_VECTOR, instruction=0 (NOP), state=IDLE.
  - mem_req=0, mem_addr=RESET_VECTOR, instr_valid=0, fetch_err=0.
- States are IDLE, FETCH, EXEC and HALTED. All outputs are registered.
- IDLE: one cycle after reset is released, then go to FETCH.
- FETCH:
  - mem_req=1 and mem_addr=pc, both held stable until ack.
  - mem_ack is sampled at each rising edge.
  - On ack: instruction<=mem_rdata, go to EXEC.
  - Ack is allowed in the first FETCH cycle, giving zero wait states.
- EXEC: lasts exactly one cycle.
  - instr_valid=1, mem_req=0.
  - The decoder's outputs, combinational from instruction, are sampled at the end of this cycle.
- Next-PC priority at the end of EXEC:
  - cnt_wr_en=1 and add_offset=1: pc<=pc+literal_adr, modulo 2^PC_WIDTH. This is an 8-bit two's-complement wrap, so 0xFF steps back by one.
  - cnt_wr_en=1 and add_offset=0: pc<=literal_adr.
  - otherwise: pc<=pc+1, wrapping 0xFF->0x00.
  - add_offset with cnt_wr_en=0 is ignored.
- After EXEC: go to HALTED if halt=1, else to FETCH.
  - The PC is still updated on the way into HALTED.
  - halt is only sampled in EXEC.
- HALTED: mem_req=0, instr_valid=0, and the block stays here until reset.
- Throughput is 2 cycles per instruction at zero wait states, plus N cycles for N memory wait states.
- mem_ack outside FETCH is ignored.
- instruction keeps its last value outside EXEC. Consumers must not act on it unless instr_valid=1.
- Reset mid-fetch:
  - All state returns to reset values on the next edge.
  - An ack arriving in the reset cycle is discarded.
- mem_rdata is don't-care when mem_ack=0.

Optional Feature:
- Macro FETCH_WATCHDOG_EN.
- Defined:
  - A wait counter clears on entry to FETCH and increments for each FETCH cycle without ack.
  - If the counter reaches WDT_LIMIT without ack: fetch_err<=1 (sticky until reset), go to HALTED, drop mem_req.
  - instruction keeps its previous value.
- Undefined: no counter is built, fetch_err is constant 0, and FETCH waits indefinitely.

Test Plan:
1. Reset, memory acks every fetch with 0 wait states, words 0x0800,0x1000,0x1800 at 0,1,2 -> mem_addr sequence 0,1,2; instr_valid pulses every 2nd cycle; instruction tracks the words.
2. GOTO: in EXEC at pc=0x05, drive cnt_wr_en=1, add_offset=0, literal_adr=0x3F -> next mem_addr=0x3F; pc=0x3F.
3. Relative jump: at pc=0x10, cnt_wr_en=1, add_offset=1, literal_adr=0x09 -> next pc=0x19; at pc=0x02 with literal_adr=0xFE -> next pc=0x00; at pc=0xFF with no jump -> next pc=0x00.
4. Wait states: ack delayed 3 cycles -> mem_req and mem_addr stable for 4 cycles; a stray ack during EXEC is ignored; reset asserted mid-FETCH -> mem_req=0, pc=RESET_VECTOR and instruction=0 after one edge.
5. Halt: halt=1 during EXEC at pc=0x07 with no jump -> pc=0x08, HALTED, no further mem_req or instr_valid until reset.
6. With FETCH_WATCHDOG_EN defined, never ack -> fetch_err=1 after WDT_LIMIT FETCH cycles, mem_req drops, fetch_err stays 1 until reset. Without the macro, the same stimulus keeps mem_req=1 indefinitely and fetch_err=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack program-memory fetch, instruction register, jump handling.
// Optional fetch watchdog enabled by defining FETCH_WATCHDOG_EN.
module fetch_unit #(
    parameter int unsigned         PC_WIDTH     = 8,
    parameter int unsigned         INSTR_WIDTH  = 16,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned         WDT_LIMIT    = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   mem_req,
    output logic [PC_WIDTH-1:0]    mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [PC_WIDTH-1:0]    pc,
    input  logic                   cnt_wr_en,
    input  logic                   add_offset,
    input  logic [PC_WIDTH-1:0]    literal_adr,
    input  logic                   halt,
    output logic                   fetch_err
);

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalted} state_e;

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   mem_req_q, valid_q;
    logic                   err_q, err_d;

`ifdef FETCH_WATCHDOG_EN
    localparam int unsigned WdtWidth = $clog2(WDT_LIMIT + 1);

    logic [WdtWidth-1:0] wdt_q, wdt_d;
    logic                wdt_expire;

    // Fires on the WDT_LIMIT-th consecutive FETCH cycle without ack.
    assign wdt_expire = (32'(wdt_q) + 32'd1 >= WDT_LIMIT);
`else
    logic unused_wdt_limit;
    assign unused_wdt_limit = ^WDT_LIMIT;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        err_d   = err_q;
`ifdef FETCH_WATCHDOG_EN
        wdt_d   = wdt_q;
`endif
        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
`ifdef FETCH_WATCHDOG_EN
                wdt_d   = '0;
`endif
            end
            StFetch: begin
                if (mem_ack) begin
                    instr_d = mem_rdata;
                    state_d = StExec;
                end
`ifdef FETCH_WATCHDOG_EN
                else if (wdt_expire) begin
                    err_d   = 1'b1;
                    state_d = StHalted;
                end else begin
                    wdt_d = wdt_q + 1'b1;
                end
`endif
            end
            StExec: begin
                if (cnt_wr_en && add_offset) begin
                    pc_d = pc_q + literal_adr;
                end else if (cnt_wr_en) begin
                    pc_d = literal_adr;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
                state_d = halt ? StHalted : StFetch;
`ifdef FETCH_WATCHDOG_EN
                wdt_d   = '0;
`endif
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Strobes are registered from the next state so every output comes straight off a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pc_q      <= RESET_VECTOR;
            instr_q   <= '0;
            mem_req_q <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef FETCH_WATCHDOG_EN
            wdt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            mem_req_q <= (state_d == StFetch);
            valid_q   <= (state_d == StExec);
            err_q     <= err_d;
`ifdef FETCH_WATCHDOG_EN
            wdt_q     <= wdt_d;
`endif
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed jumps/halt/reset plus randomized fetch traffic
// checked against a transaction-level PC/instruction model.
module tb_fetch_unit;

    localparam int PW  = 8;
    localparam int IW  = 16;
    localparam int WDT = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_req;
    logic [PW-1:0] mem_addr;
    logic          mem_ack;
    logic [IW-1:0] mem_rdata;
    logic [IW-1:0] instruction;
    logic          instr_valid;
    logic [PW-1:0] pc;
    logic          cnt_wr_en;
    logic          add_offset;
    logic [PW-1:0] literal_adr;
    logic          halt;
    logic          fetch_err;

    always #5 clk = ~clk;

    fetch_unit #(
        .PC_WIDTH    (PW),
        .INSTR_WIDTH (IW),
        .RESET_VECTOR(8'h00),
        .WDT_LIMIT   (WDT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .pc         (pc),
        .cnt_wr_en  (cnt_wr_en),
        .add_offset (add_offset),
        .literal_adr(literal_adr),
        .halt       (halt),
        .fetch_err  (fetch_err)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [IW-1:0] mem [256];
    int            m_pc;
    logic [IW-1:0] m_instr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        mem_ack   = 1'b0;
        cnt_wr_en = 1'b0;
        halt      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);
        check("rst_instr", 32'(instruction), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        m_pc    = 0;
        m_instr = '0;
    endtask

    // Called at a negedge where the DUT should be in a FETCH cycle for m_pc.
    task automatic do_instr(input int waits, input bit cw, input bit ao, input int lit,
                            input bit hl);
        check("fetch_req", 32'(mem_req), 32'd1);
        check("fetch_addr", 32'(mem_addr), 32'(m_pc));
        check("fetch_pc", 32'(pc), 32'(m_pc));
        check("fetch_valid", 32'(instr_valid), 32'd0);
        check("instr_hold", 32'(instruction), 32'(m_instr));
        for (int w = 0; w < waits; w++) begin
            mem_ack   = 1'b0;
            mem_rdata = 16'($urandom);
            @(negedge clk);
            check("wait_req", 32'(mem_req), 32'd1);
            check("wait_addr", 32'(mem_addr), 32'(m_pc));
            check("wait_valid", 32'(instr_valid), 32'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = mem[m_pc];
        @(negedge clk);
        m_instr = mem[m_pc];
        check("exec_valid", 32'(instr_valid), 32'd1);
        check("exec_req", 32'(mem_req), 32'd0);
        check("exec_instr", 32'(instruction), 32'(m_instr));
        check("exec_pc", 32'(pc), 32'(m_pc));
        // A stray ack with garbage data during EXEC must not reach the instruction register.
        mem_ack     = 1'($urandom);
        mem_rdata   = 16'($urandom);
        cnt_wr_en   = cw;
        add_offset  = ao;
        literal_adr = 8'(lit);
        halt        = hl;
        @(negedge clk);
        mem_ack     = 1'b0;
        cnt_wr_en   = 1'b0;
        add_offset  = 1'($urandom);
        literal_adr = 8'($urandom);
        halt        = 1'b0;
        if (cw && ao) m_pc = (m_pc + lit) % 256;
        else if (cw)  m_pc = lit % 256;
        else          m_pc = (m_pc + 1) % 256;
    endtask

    initial begin
        reset       = 1'b1;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        cnt_wr_en   = 1'b0;
        add_offset  = 1'b0;
        literal_adr = '0;
        halt        = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h0800;
        mem[1] = 16'h1000;
        mem[2] = 16'h1800;

        // Zero-wait sequential fetch of the first three words
        reset_dut();
        for (int i = 0; i < 3; i++) do_instr(0, 1'b0, 1'($urandom), int'($urandom_range(0, 255)), 1'b0);

        // Absolute and relative jumps, including wrap cases
        do_instr(0, 1'b0, 1'b1, 8'h55, 1'b0);
        do_instr(0, 1'b0, 1'b0, 8'h00, 1'b0);
        do_instr(0, 1'b1, 1'b0, 8'h3F, 1'b0);
        do_instr(1, 1'b1, 1'b0, 8'h10, 1'b0);
        do_instr(0, 1'b1, 1'b1, 8'h09, 1'b0);
        do_instr(0, 1'b1, 1'b0, 8'h02, 1'b0);
        do_instr(2, 1'b1, 1'b1, 8'hFE, 1'b0);
        do_instr(0, 1'b1, 1'b0, 8'hFF, 1'b0);
        do_instr(0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Three wait states, then randomized traffic
        do_instr(3, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 40; i++) begin
            do_instr(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                     int'($urandom_range(0, 255)), 1'b0);
        end

        // Reset in the middle of a fetch, with an ack in the reset cycle
        mem_ack = 1'b0;
        @(negedge clk);
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        @(negedge clk);
        check("midrst_req", 32'(mem_req), 32'd0);
        check("midrst_pc", 32'(pc), 32'd0);
        check("midrst_instr", 32'(instruction), 32'd0);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        reset   = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        m_pc    = 0;
        m_instr = '0;
        do_instr(0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Halt at pc 0x07 without a jump: pc advances to 0x08 and everything stops
        do_instr(0, 1'b1, 1'b0, 8'h07, 1'b0);
        do_instr(1, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) begin
            mem_ack   = 1'($urandom);
            mem_rdata = 16'($urandom);
            @(negedge clk);
            check("halt_req", 32'(mem_req), 32'd0);
            check("halt_valid", 32'(instr_valid), 32'd0);
            check("halt_pc", 32'(pc), 32'h08);
            check("halt_instr", 32'(instruction), 32'(m_instr));
        end

        // Memory never acks
        reset_dut();
        mem_ack = 1'b0;
`ifdef FETCH_WATCHDOG_EN
        begin
            int req_cycles = 0;
            for (int i = 0; i < 100 && mem_req === 1'b1; i++) begin
                req_cycles++;
                @(negedge clk);
            end
            check("wdt_cycles", 32'(req_cycles), 32'(WDT));
            check("wdt_err", 32'(fetch_err), 32'd1);
            check("wdt_req", 32'(mem_req), 32'd0);
            check("wdt_instr", 32'(instruction), 32'd0);
            for (int i = 0; i < 5; i++) begin
                mem_ack   = 1'($urandom);
                mem_rdata = 16'($urandom);
                @(negedge clk);
                check("wdt_sticky", 32'(fetch_err), 32'd1);
                check("wdt_stay", 32'(mem_req), 32'd0);
            end
            reset_dut();
        end
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("nowdt_req", 32'(mem_req), 32'd1);
            check("nowdt_err", 32'(fetch_err), 32'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
